// File: rtl/lane_pkg.sv
// Shared definitions for the lane frame loader.
// Holds the fixed lane count, the loader state encoding and the lane
// index type used by the top-level loader and its testbench.
package lane_pkg;

    // The frame is always exactly 26 lanes wide (data_a .. data_z).
    localparam int NUM_LANES = 26;

    // Index of the final lane (data_z).
    localparam logic [4:0] LAST_IDX = 5'd25;

    // The lane index counter runs 0..25, so five bits are enough.
    typedef logic [4:0] idx_t;

    // FILL: collecting bytes into the lanes.
    // HOLD: presenting a finished frame to the consumer.
    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/lane_frame_loader_if.sv
// Serial byte-stream bus that feeds the lane frame loader.
// Signals:
//   in_data  - byte being offered by the source
//   in_valid - in_data is valid this cycle
//   in_last  - the offered byte is the final byte of its frame
//   in_ready - the loader accepts a byte this cycle
// Modports:
//   master - the byte source
//   slave  - the loader
interface lane_frame_loader_if #(
    parameter int LANE_W = 8
);
    logic [LANE_W-1:0] in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;

    modport master (
        output in_data,
        output in_valid,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  in_last,
        output in_ready
    );
endinterface

// File: rtl/lane_sum_acc.sv
// 16-bit clearable accumulator with add-enable.
// Ports:
//   clk_i   - clock, rising edge
//   rst_i   - synchronous active-high reset, forces sum to zero
//   clear   - zero the sum on the next edge (wins over add_en)
//   add_en  - add add_val to the sum on the next edge
//   add_val - value to add
//   sum     - running total
module lane_sum_acc (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear,
    input  logic        add_en,
    input  logic [15:0] add_val,
    output logic [15:0] sum
);

    // Running total. Clear has priority so a handshake and a stray add
    // in the same cycle always leave the next frame starting from zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sum <= '0;
        end else if (clear) begin
            sum <= '0;
        end else if (add_en) begin
            sum <= sum + add_val;
        end
    end

endmodule

// File: rtl/lane_frame_loader.sv
// Serial-to-parallel frame loader.
// Collects up to 26 bytes from a valid/ready byte stream into 26 parallel
// lanes (data_a first), then holds the finished frame until the consumer
// takes it with frame_ready. A frame ended early by in_last has its
// remaining lanes zeroed and is flagged with frame_short. frame_sum is the
// sum of all 26 lanes of the presented frame.
// Ports:
//   clk_i, rst_i      - clock and synchronous active-high reset
//   in_bus            - byte stream (lane_frame_loader_if.slave)
//   data_a .. data_z  - parallel lanes
//   frame_valid       - lanes hold a complete frame
//   frame_ready       - consumer takes the frame
//   frame_short       - frame ended early and was zero-padded
//   frame_sum         - sum of all lanes of the frame
module lane_frame_loader
    import lane_pkg::*;
#(
    parameter int LANE_W = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    lane_frame_loader_if.slave  in_bus,
    output logic [LANE_W-1:0]   data_a,
    output logic [LANE_W-1:0]   data_b,
    output logic [LANE_W-1:0]   data_c,
    output logic [LANE_W-1:0]   data_d,
    output logic [LANE_W-1:0]   data_e,
    output logic [LANE_W-1:0]   data_f,
    output logic [LANE_W-1:0]   data_g,
    output logic [LANE_W-1:0]   data_h,
    output logic [LANE_W-1:0]   data_i,
    output logic [LANE_W-1:0]   data_j,
    output logic [LANE_W-1:0]   data_k,
    output logic [LANE_W-1:0]   data_l,
    output logic [LANE_W-1:0]   data_m,
    output logic [LANE_W-1:0]   data_n,
    output logic [LANE_W-1:0]   data_o,
    output logic [LANE_W-1:0]   data_p,
    output logic [LANE_W-1:0]   data_q,
    output logic [LANE_W-1:0]   data_r,
    output logic [LANE_W-1:0]   data_s,
    output logic [LANE_W-1:0]   data_t,
    output logic [LANE_W-1:0]   data_u,
    output logic [LANE_W-1:0]   data_v,
    output logic [LANE_W-1:0]   data_w,
    output logic [LANE_W-1:0]   data_x,
    output logic [LANE_W-1:0]   data_y,
    output logic [LANE_W-1:0]   data_z,
    output logic                frame_valid,
    input  logic                frame_ready,
    output logic                frame_short,
    output logic [15:0]         frame_sum
);

    state_t            state;
    state_t            state_nxt;
    idx_t              idx;
    logic              fill_ready;
    logic              accept;
    logic              frame_end;
    logic              handshake;
    logic [LANE_W-1:0] lanes [NUM_LANES];

    assign in_bus.in_ready = fill_ready;
    assign accept          = in_bus.in_valid && fill_ready;
    // A frame closes on the 26th byte regardless of in_last, or earlier on in_last.
    assign frame_end       = (idx == LAST_IDX) || in_bus.in_last;
    assign handshake       = (state == HOLD) && frame_ready;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs. Both outputs decode the registered
    // state only, so frame_ready never reaches in_ready combinationally.
    always_comb begin
        state_nxt   = state;
        fill_ready  = 1'b0;
        frame_valid = 1'b0;
        case (state)
            FILL: begin
                fill_ready = 1'b1;
                if (accept && frame_end) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                frame_valid = 1'b1;
                if (frame_ready) begin
                    state_nxt = FILL;
                end
            end
            default: begin
                state_nxt = FILL;
            end
        endcase
    end

    // Lane index. It parks on the closing lane while the frame is held and
    // returns to zero only when the consumer takes the frame.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx <= '0;
        end else if (handshake) begin
            idx <= '0;
        end else if (accept && !frame_end) begin
            idx <= idx + idx_t'(1);
        end
    end

    // Lane storage. The accepted byte lands in lane idx; a byte carrying
    // in_last also zeroes every lane above it in the same edge, so the
    // padding is visible together with frame_valid. Untouched lanes keep
    // the previous frame's contents.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                lanes[i] <= '0;
            end
        end else if (accept) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (idx_t'(i) == idx) begin
                    lanes[i] <= in_bus.in_data;
                end else if (in_bus.in_last && (idx_t'(i) > idx)) begin
                    lanes[i] <= '0;
                end
            end
        end
    end

    // Short-frame flag: set when in_last closes the frame before lane 25,
    // cleared when the consumer takes the frame.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            frame_short <= 1'b0;
        end else if (handshake) begin
            frame_short <= 1'b0;
        end else if (accept && in_bus.in_last && (idx != LAST_IDX)) begin
            frame_short <= 1'b1;
        end
    end

    // Sum of accepted bytes; padded lanes are zero so they add nothing.
    lane_sum_acc u_sum_acc (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear   (handshake),
        .add_en  (accept),
        .add_val (16'(in_bus.in_data)),
        .sum     (frame_sum)
    );

    assign data_a = lanes[0];
    assign data_b = lanes[1];
    assign data_c = lanes[2];
    assign data_d = lanes[3];
    assign data_e = lanes[4];
    assign data_f = lanes[5];
    assign data_g = lanes[6];
    assign data_h = lanes[7];
    assign data_i = lanes[8];
    assign data_j = lanes[9];
    assign data_k = lanes[10];
    assign data_l = lanes[11];
    assign data_m = lanes[12];
    assign data_n = lanes[13];
    assign data_o = lanes[14];
    assign data_p = lanes[15];
    assign data_q = lanes[16];
    assign data_r = lanes[17];
    assign data_s = lanes[18];
    assign data_t = lanes[19];
    assign data_u = lanes[20];
    assign data_v = lanes[21];
    assign data_w = lanes[22];
    assign data_x = lanes[23];
    assign data_y = lanes[24];
    assign data_z = lanes[25];

endmodule

// File: tb/tb_lane_frame_loader.sv
// Directed testbench for lane_frame_loader.
// Drives the byte stream through the interface, presents frames with and
// without backpressure, and compares lanes, flags and sums against
// hand-computed values.
module tb_lane_frame_loader;

    logic        clk_i;
    logic        rst_i;
    logic        frame_ready;
    logic        frame_valid;
    logic        frame_short;
    logic [15:0] frame_sum;
    logic [7:0]  data_a, data_b, data_c, data_d, data_e, data_f, data_g;
    logic [7:0]  data_h, data_i, data_j, data_k, data_l, data_m, data_n;
    logic [7:0]  data_o, data_p, data_q, data_r, data_s, data_t, data_u;
    logic [7:0]  data_v, data_w, data_x, data_y, data_z;

    int checkCount;
    int errorCount;
    int stallCount;

    lane_frame_loader_if #(.LANE_W(8)) in_bus ();

    lane_frame_loader #(.LANE_W(8)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_bus      (in_bus),
        .data_a      (data_a), .data_b (data_b), .data_c (data_c), .data_d (data_d),
        .data_e      (data_e), .data_f (data_f), .data_g (data_g), .data_h (data_h),
        .data_i      (data_i), .data_j (data_j), .data_k (data_k), .data_l (data_l),
        .data_m      (data_m), .data_n (data_n), .data_o (data_o), .data_p (data_p),
        .data_q      (data_q), .data_r (data_r), .data_s (data_s), .data_t (data_t),
        .data_u      (data_u), .data_v (data_v), .data_w (data_w), .data_x (data_x),
        .data_y      (data_y), .data_z (data_z),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .frame_short (frame_short),
        .frame_sum   (frame_sum)
    );

    // 100 MHz clock.
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Compare one observed value with its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic stepCycle();
        @(posedge clk_i);
        #1;
    endtask

    // Put a value on the byte bus.
    task automatic applyStimulus(input logic [7:0] d, input logic v, input logic l);
        in_bus.in_data  = d;
        in_bus.in_valid = v;
        in_bus.in_last  = l;
    endtask

    // Offer one byte and wait (bounded) until it is accepted. in_valid stays
    // high afterwards so consecutive calls stream without gaps, except after
    // a last byte where it drops.
    task automatic sendByte(input logic [7:0] d, input logic l);
        int waitCycles;
        applyStimulus(d, 1'b1, l);
        waitCycles = 0;
        while (in_bus.in_ready !== 1'b1 && waitCycles < 50) begin
            stepCycle();
            waitCycles++;
            stallCount++;
        end
        if (waitCycles >= 50) begin
            checkOutput("in_ready_timeout", 32'(in_bus.in_ready), 32'h1);
        end
        stepCycle();
        if (l) begin
            applyStimulus(8'h00, 1'b0, 1'b0);
        end
    endtask

    // Hold the bus idle for n cycles.
    task automatic idleCycles(input int n);
        applyStimulus(8'h00, 1'b0, 1'b0);
        for (int k = 0; k < n; k++) begin
            stepCycle();
        end
    endtask

    // Synchronous reset pulse.
    task automatic pulseReset();
        rst_i = 1'b1;
        stepCycle();
        stepCycle();
        rst_i = 1'b0;
    endtask

    initial begin
        logic [7:0]  heldA;
        logic [15:0] heldSum;

        checkCount  = 0;
        errorCount  = 0;
        stallCount  = 0;
        frame_ready = 1'b0;
        rst_i       = 1'b0;
        applyStimulus(8'h00, 1'b0, 1'b0);

        // Reset state.
        pulseReset();
        checkOutput("rst_in_ready", 32'(in_bus.in_ready), 32'h1);
        checkOutput("rst_frame_valid", 32'(frame_valid), 32'h0);
        checkOutput("rst_frame_short", 32'(frame_short), 32'h0);
        checkOutput("rst_frame_sum", 32'(frame_sum), 32'h0);
        checkOutput("rst_data_a", 32'(data_a), 32'h0);
        checkOutput("rst_data_z", 32'(data_z), 32'h0);
        stepCycle();
        checkOutput("rst_in_ready_later", 32'(in_bus.in_ready), 32'h1);

        // Full frame 0x01..0x1A with frame_ready held high.
        $display("[TB] full frame");
        frame_ready = 1'b1;
        for (int i = 0; i < 25; i++) begin
            sendByte(8'(i + 1), 1'b0);
        end
        checkOutput("full_valid_before_last", 32'(frame_valid), 32'h0);
        sendByte(8'h1A, 1'b0);
        applyStimulus(8'h00, 1'b0, 1'b0);
        checkOutput("full_valid", 32'(frame_valid), 32'h1);
        checkOutput("full_in_ready", 32'(in_bus.in_ready), 32'h0);
        checkOutput("full_data_a", 32'(data_a), 32'h01);
        checkOutput("full_data_m", 32'(data_m), 32'h0D);
        checkOutput("full_data_z", 32'(data_z), 32'h1A);
        checkOutput("full_sum", 32'(frame_sum), 32'h015F);
        checkOutput("full_short", 32'(frame_short), 32'h0);
        stepCycle();
        checkOutput("full_after_valid", 32'(frame_valid), 32'h0);
        checkOutput("full_after_ready", 32'(in_bus.in_ready), 32'h1);
        checkOutput("full_after_sum", 32'(frame_sum), 32'h0);

        // Short frame of three 0xFF bytes, then 10 cycles of backpressure
        // with traffic on the bus that must not be consumed.
        $display("[TB] short frame with backpressure");
        frame_ready = 1'b0;
        sendByte(8'hFF, 1'b0);
        sendByte(8'hFF, 1'b0);
        sendByte(8'hFF, 1'b1);
        checkOutput("short_valid", 32'(frame_valid), 32'h1);
        checkOutput("short_data_a", 32'(data_a), 32'hFF);
        checkOutput("short_data_c", 32'(data_c), 32'hFF);
        checkOutput("short_data_d", 32'(data_d), 32'h00);
        checkOutput("short_data_m", 32'(data_m), 32'h00);
        checkOutput("short_data_z", 32'(data_z), 32'h00);
        checkOutput("short_sum", 32'(frame_sum), 32'h02FD);
        checkOutput("short_flag", 32'(frame_short), 32'h1);
        heldA   = data_a;
        heldSum = frame_sum;
        applyStimulus(8'h55, 1'b1, 1'b1);
        for (int k = 0; k < 10; k++) begin
            stepCycle();
            checkOutput("bp_in_ready", 32'(in_bus.in_ready), 32'h0);
            checkOutput("bp_valid", 32'(frame_valid), 32'h1);
        end
        checkOutput("bp_data_a", 32'(data_a), 32'(heldA));
        checkOutput("bp_data_d", 32'(data_d), 32'h00);
        checkOutput("bp_sum", 32'(frame_sum), 32'(heldSum));
        checkOutput("bp_short", 32'(frame_short), 32'h1);
        applyStimulus(8'h00, 1'b0, 1'b0);
        frame_ready = 1'b1;
        stepCycle();
        frame_ready = 1'b0;
        checkOutput("bp_release_valid", 32'(frame_valid), 32'h0);
        checkOutput("bp_release_ready", 32'(in_bus.in_ready), 32'h1);
        checkOutput("bp_release_short", 32'(frame_short), 32'h0);
        checkOutput("bp_release_sum", 32'(frame_sum), 32'h0);

        // Gappy input: 26 bytes of 0xFF with random idle cycles in between.
        $display("[TB] gappy frame");
        for (int i = 0; i < 26; i++) begin
            idleCycles(int'($urandom_range(0, 2)));
            sendByte(8'hFF, 1'b0);
        end
        applyStimulus(8'h00, 1'b0, 1'b0);
        checkOutput("gappy_valid", 32'(frame_valid), 32'h1);
        checkOutput("gappy_sum", 32'(frame_sum), 32'h19E6);
        checkOutput("gappy_data_d", 32'(data_d), 32'hFF);
        checkOutput("gappy_data_z", 32'(data_z), 32'hFF);
        checkOutput("gappy_short", 32'(frame_short), 32'h0);
        frame_ready = 1'b1;
        stepCycle();
        frame_ready = 1'b0;

        // Reset after 12 bytes, then a full frame of 0xAA.
        $display("[TB] reset mid-frame");
        for (int i = 0; i < 12; i++) begin
            sendByte(8'h11, 1'b0);
        end
        applyStimulus(8'h00, 1'b0, 1'b0);
        pulseReset();
        checkOutput("midrst_in_ready", 32'(in_bus.in_ready), 32'h1);
        checkOutput("midrst_sum", 32'(frame_sum), 32'h0);
        checkOutput("midrst_data_a", 32'(data_a), 32'h0);
        for (int i = 0; i < 26; i++) begin
            sendByte(8'hAA, 1'b0);
        end
        applyStimulus(8'h00, 1'b0, 1'b0);
        checkOutput("aa_valid", 32'(frame_valid), 32'h1);
        checkOutput("aa_sum", 32'(frame_sum), 32'h1144);
        checkOutput("aa_short", 32'(frame_short), 32'h0);
        checkOutput("aa_data_a", 32'(data_a), 32'hAA);
        checkOutput("aa_data_l", 32'(data_l), 32'hAA);
        checkOutput("aa_data_z", 32'(data_z), 32'hAA);
        frame_ready = 1'b1;
        stepCycle();

        // Back-to-back: two frames with frame_ready tied high and in_valid
        // never dropping. Frame two is 0x10..0x29, sum 741 = 0x2E5.
        $display("[TB] back-to-back frames");
        stallCount = 0;
        for (int i = 0; i < 26; i++) begin
            sendByte(8'(i + 1), 1'b0);
        end
        checkOutput("b2b_f1_valid", 32'(frame_valid), 32'h1);
        checkOutput("b2b_f1_sum", 32'(frame_sum), 32'h015F);
        for (int i = 0; i < 26; i++) begin
            sendByte(8'(i + 16), 1'b0);
        end
        applyStimulus(8'h00, 1'b0, 1'b0);
        checkOutput("b2b_f2_valid", 32'(frame_valid), 32'h1);
        checkOutput("b2b_f2_sum", 32'(frame_sum), 32'h02E5);
        checkOutput("b2b_f2_data_a", 32'(data_a), 32'h10);
        checkOutput("b2b_f2_data_z", 32'(data_z), 32'h29);
        checkOutput("b2b_stalls", 32'(stallCount), 32'h1);
        stepCycle();
        checkOutput("b2b_end_valid", 32'(frame_valid), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] simulation timed out");
    end

endmodule

// File: doc/lane_frame_loader.md
LANE_FRAME_LOADER -- requirements
Module: lane_frame_loader

Interface
REQ-001 Parameter: LANE_W, default 8, width of the input byte and of each output lane; the lane count is fixed at 26.
REQ-002 Port: clk_i  input  1  sole clock; all logic is rising-edge.
REQ-003 Port: rst_i  input  1  synchronous, active-high reset.
REQ-004 Port: in_data  input  LANE_W  serial byte stream.
REQ-005 Port: in_valid  input  1  in_data is valid.
REQ-006 Port: in_last  input  1  the current byte is the final byte of the frame.
REQ-007 Port: in_ready  output  1  the loader accepts a byte this cycle.
REQ-008 Port: data_a .. data_z  output  LANE_W each  26 parallel lanes; data_a is the first byte received.
REQ-009 Port: frame_valid  output  1  the lanes hold a complete frame.
REQ-010 Port: frame_ready  input  1  the downstream consumer takes the frame.
REQ-011 Port: frame_short  output  1  the current frame ended early by in_last and was zero-padded.
REQ-012 Port: frame_sum  output  16  unsigned sum of all 26 lanes of the current frame.

Function
REQ-013 The loader shall implement two states, FILL and HOLD; the reset state is FILL.
REQ-014 in_ready shall equal 1 in FILL and 0 in HOLD, with no combinational path from frame_ready to in_ready.
REQ-015 A byte is accepted when in_valid and in_ready are both 1 in the same cycle; the byte shall be written to lane index idx (0 = data_a ... 25 = data_z), and idx shall increment.
REQ-016 idx shall be a 5-bit counter running 0..25; it shall never exceed 25.
REQ-017 Acceptance at idx = 25 shall move the state to HOLD on the next edge, with frame_valid = 1 and frame_short = 0, whatever the value of in_last.
REQ-018 Acceptance with in_last = 1 and idx < 25 shall zero every lane above idx, set frame_short = 1, and enter HOLD; all of this becomes visible in the same next cycle.
REQ-019 frame_sum shall be accumulated per accepted byte (zero-extended to 16 bits) and shall be valid whenever frame_valid = 1; padded zero lanes contribute 0; the maximum value is 6630, so no overflow occurs.
REQ-020 In HOLD, data_a..data_z, frame_short and frame_sum shall stay stable while frame_valid = 1 and frame_ready = 0.
REQ-021 In HOLD, frame_ready = 1 shall complete the frame handshake: the next cycle shall be FILL with frame_valid = 0, idx = 0, the accumulator = 0, and frame_short = 0.
REQ-022 Lanes shall keep the previous frame's values after the handshake until they are overwritten, so the lanes are don't-care whenever frame_valid = 0.
REQ-023 frame_ready shall be ignored in FILL.
REQ-024 in_valid and in_last shall be ignored in HOLD, and no byte shall be consumed there.
REQ-025 Latency: frame_valid shall rise exactly one cycle after the final byte is accepted.
REQ-026 Throughput: 26 bytes in 26 cycles, plus one HOLD cycle minimum per frame.

Reset
REQ-027 rst_i = 1 at a rising edge shall force state = FILL, idx = 0, accumulator = 0, frame_valid = 0, frame_short = 0, and all lanes = 0.
REQ-028 Reset asserted in the middle of a fill or during HOLD shall discard the partial or held frame with no handshake.
REQ-029 in_ready shall be 1 in the first cycle after reset is released.

Structure
REQ-030 The shared package lane_pkg shall hold NUM_LANES = 26, the state enum (FILL, HOLD) and the lane-index type.
REQ-031 One sub-module, lane_sum_acc, shall be used: a 16-bit clearable accumulator with add-enable.
REQ-032 Lane storage shall be an array of 26 LANE_W registers mapped onto the named ports.

Verification
REQ-033 Full frame: bytes 0x01..0x1A with in_valid held high, frame_ready = 1 -> data_a = 0x01, data_z = 0x1A, frame_sum = 0x015F, frame_short = 0; frame_valid high one cycle after the last byte.
REQ-034 Short frame: bytes 0xFF, 0xFF, 0xFF with in_last on the third byte -> data_a..data_c = 0xFF, data_d..data_z = 0, frame_sum = 0x02FD, frame_short = 1.
REQ-035 Backpressure: frame_ready held at 0 for 10 cycles in HOLD -> in_ready = 0, lanes and sum stable, in_valid traffic not consumed; frame_ready = 1 -> FILL with idx = 0 next cycle.
REQ-036 Gappy input: in_valid toggled randomly over 26 bytes of 0xFF -> frame_sum = 0x19E6, and data_a..data_z in order.
REQ-037 Reset mid-operation: rst_i pulsed after 12 bytes, then a full frame of 0xAA -> first frame lost, frame_sum = 0x1144, frame_short = 0.
REQ-038 Back-to-back: two frames with frame_ready tied to 1 -> exactly one in_ready = 0 cycle between frames, and both sums correct.
